// File: rtl/cam_pixel_packer.sv
// Pairs AL422B FIFO reader bytes into 16-bit pixels with column/row tags and a 4-deep valid/ready output FIFO.
// Optional CAM_GRAY_EN replaces the RGB565 word with {8'h00, luma}.
module cam_pixel_packer #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int CW     = 9,
  parameter int RW     = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    cam_dout,
  input  logic          cam_rdclk,
  output logic          leer,
  output logic [15:0]   pix_data,
  output logic [CW-1:0] pix_col,
  output logic [RW-1:0] pix_row,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic          busy,
  output logic          done,
  output logic          overflow
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  localparam int EW = 16 + CW + RW;

  state_t        state;
  logic          rdclk_q;
  logic          phase;
  logic [7:0]    hi;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [EW-1:0] mem [4];
  logic [1:0]    wr_ptr, rd_ptr;
  logic [2:0]    count, cnt_nxt;
  logic          take, push, pop, drop, write, last;
  logic [15:0]   push_data;

  assign take  = !rdclk_q && cam_rdclk && (state == READ);
  assign push  = take && phase;
  assign pop   = (count != 3'd0) && pix_ready;
  assign drop  = push && (count == 3'd4) && !pop;
  assign write = push && !drop;
  assign last  = push && (col == CW'(WIDTH - 1)) && (row == RW'(HEIGHT - 1));

`ifdef CAM_GRAY_EN
  logic [7:0]  r8, g8, b8;
  logic [10:0] y_sum;
  always_comb begin
    r8        = {hi[7:3], 3'b000};
    g8        = {hi[2:0], cam_dout[7:5], 2'b00};
    b8        = {cam_dout[4:0], 3'b000};
    y_sum     = (11'(r8) << 1) + 11'(g8) * 11'd5 + 11'(b8);
    push_data = {8'h00, y_sum[10:3]};
  end
`else
  assign push_data = {hi, cam_dout};
`endif

  always_comb begin
    cnt_nxt = count;
    if (write && !pop)
      cnt_nxt = count + 3'd1;
    else if (!write && pop)
      cnt_nxt = count - 3'd1;
  end

  assign {pix_data, pix_col, pix_row} = mem[rd_ptr];
  assign pix_valid = (count != 3'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      rdclk_q  <= 1'b0;
      phase    <= 1'b0;
      hi       <= '0;
      col      <= '0;
      row      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      leer     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      for (int unsigned i = 0; i < 4; i++)
        mem[i] <= '0;
    end else begin
      rdclk_q <= cam_rdclk;

      // When full, a simultaneous pop frees the slot wr_ptr points at, so writing it is safe.
      if (write) begin
        mem[wr_ptr] <= {push_data, col, row};
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 2'd1;
      count <= cnt_nxt;

      case (state)
        IDLE: begin
          leer <= 1'b0;
          if (start) begin
            state    <= READ;
            busy     <= 1'b1;
            leer     <= 1'b1;
            done     <= 1'b0;
            overflow <= 1'b0;
            phase    <= 1'b0;
            col      <= '0;
            row      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
          end
        end
        READ: begin
          if (take) begin
            phase <= ~phase;
            if (!phase)
              hi <= cam_dout;
          end
          if (push) begin
            if (drop)
              overflow <= 1'b1;
            if (col == CW'(WIDTH - 1)) begin
              col <= '0;
              row <= row + RW'(1);
            end else begin
              col <= col + CW'(1);
            end
          end
          if (last) begin
            state <= DRAIN;
            leer  <= 1'b0;
          end else begin
            leer <= (cnt_nxt <= 3'd2);
          end
        end
        DRAIN: begin
          leer <= 1'b0;
          if (count == 3'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_pixel_packer.sv
// Directed bench for cam_pixel_packer on a 4x2 frame; honours CAM_GRAY_EN for expected pixel words.
module tb_cam_pixel_packer;

  localparam int W = 4;
  localparam int H = 2;
  localparam int CWB = 3;
  localparam int RWB = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [7:0]     cam_dout = '0;
  logic           cam_rdclk = 1'b0;
  logic           leer;
  logic [15:0]    pix_data;
  logic [CWB-1:0] pix_col;
  logic [RWB-1:0] pix_row;
  logic           pix_valid;
  logic           pix_ready = 1'b0;
  logic           busy, done, overflow;

  int vectors = 0;
  int miscompares = 0;

  cam_pixel_packer #(.WIDTH(W), .HEIGHT(H), .CW(CWB), .RW(RWB)) dut (
    .clk(clk), .reset(reset), .start(start), .cam_dout(cam_dout),
    .cam_rdclk(cam_rdclk), .leer(leer), .pix_data(pix_data),
    .pix_col(pix_col), .pix_row(pix_row), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] raw;
    int          col;
    int          row;
  } vec_t;

  vec_t frame_a [8];

  function automatic logic [15:0] exp_pix(input logic [15:0] w);
`ifdef CAM_GRAY_EN
    int r8, g8, b8;
    r8 = int'(w[15:11]) * 8;
    g8 = int'(w[10:5]) * 4;
    b8 = int'(w[4:0]) * 8;
    return 16'((2 * r8 + 5 * g8 + b8) / 8);
`else
    return w;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic strobe_byte(input logic [7:0] b);
    @(posedge clk); #1;
    cam_dout  = b;
    cam_rdclk = 1'b1;
    @(posedge clk); #1;
    cam_rdclk = 1'b0;
  endtask

  task automatic send_pixel(input logic [15:0] w);
    strobe_byte(w[15:8]);
    strobe_byte(w[7:0]);
  endtask

  task automatic pulse_start;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic chk_head(input string name, input logic [15:0] d, input int c, input int r);
    chk({name, "_valid"}, 32'(pix_valid), 32'd1);
    chk({name, "_data"}, 32'(pix_data), 32'(d));
    chk({name, "_col"}, 32'(pix_col), 32'(c));
    chk({name, "_row"}, 32'(pix_row), 32'(r));
  endtask

  task automatic wait_done;
    for (int i = 0; i < 30 && !done; i++) @(negedge clk);
    chk("done_within_bound", 32'(done), 32'd1);
  endtask

  initial begin
    frame_a[0] = '{16'h1234, 0, 0};
    frame_a[1] = '{16'h5678, 1, 0};
    frame_a[2] = '{16'h9ABC, 2, 0};
    frame_a[3] = '{16'hDEF0, 3, 0};
    frame_a[4] = '{16'hFFFF, 0, 1};
    frame_a[5] = '{16'hF800, 1, 1};
    frame_a[6] = '{16'h001F, 2, 1};
    frame_a[7] = '{16'h07E0, 3, 1};

    // Reset held with the read clock toggling
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 cam_rdclk = ~cam_rdclk;
    end
    @(negedge clk);
    chk("rst_leer", 32'(leer), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_valid", 32'(pix_valid), 32'd0);
    chk("rst_data", 32'(pix_data), 32'd0);
    chk("rst_col", 32'(pix_col), 32'd0);
    chk("rst_row", 32'(pix_row), 32'd0);
    @(posedge clk); #1 reset = 1'b1; cam_rdclk = 1'b0;

    // Frame A: full frame, consumer always ready
    pix_ready = 1'b1;
    pulse_start;
    @(negedge clk);
    chk("a_busy", 32'(busy), 32'd1);
    chk("a_leer", 32'(leer), 32'd1);
    for (int i = 0; i < 8; i++) begin
      send_pixel(frame_a[i].raw);
      @(negedge clk);
      chk_head($sformatf("a_pix%0d", i), exp_pix(frame_a[i].raw), frame_a[i].col, frame_a[i].row);
    end
    wait_done;
    chk("a_busy_end", 32'(busy), 32'd0);
    chk("a_leer_end", 32'(leer), 32'd0);
    chk("a_valid_end", 32'(pix_valid), 32'd0);
    chk("a_ovf_end", 32'(overflow), 32'd0);

    // Frame B: back-pressure, full-FIFO push/pop, then overflow
    pix_ready = 1'b0;
    pulse_start;
    @(negedge clk);
    chk("b_done_cleared", 32'(done), 32'd0);
    send_pixel(16'h1111);
    send_pixel(16'h2222);
    @(negedge clk);
    chk("b_leer_cnt2", 32'(leer), 32'd1);
    send_pixel(16'h3333);
    @(negedge clk);
    chk("b_leer_cnt3", 32'(leer), 32'd0);
    send_pixel(16'h4444);
    @(negedge clk);
    chk("b_leer_cnt4", 32'(leer), 32'd0);
    chk("b_ovf_cnt4", 32'(overflow), 32'd0);
    chk_head("b_head_full", exp_pix(16'h1111), 0, 0);
    strobe_byte(8'h55);
    @(posedge clk); #1;
    cam_dout = 8'h55; cam_rdclk = 1'b1; pix_ready = 1'b1;
    @(posedge clk); #1;
    cam_rdclk = 1'b0; pix_ready = 1'b0;
    @(negedge clk);
    chk("b_ovf_pushpop", 32'(overflow), 32'd0);
    chk_head("b_head_after_pop", exp_pix(16'h2222), 1, 0);
    send_pixel(16'h6666);
    @(negedge clk);
    chk("b_ovf_drop", 32'(overflow), 32'd1);
    pulse_start;
    @(negedge clk);
    chk("b_start_ignored_ovf", 32'(overflow), 32'd1);
    chk("b_start_ignored_busy", 32'(busy), 32'd1);
    @(posedge clk); #1 pix_ready = 1'b1;
    @(negedge clk); chk_head("b_drain0", exp_pix(16'h2222), 1, 0);
    @(negedge clk); chk_head("b_drain1", exp_pix(16'h3333), 2, 0);
    @(negedge clk); chk_head("b_drain2", exp_pix(16'h4444), 3, 0);
    @(negedge clk); chk_head("b_drain3", exp_pix(16'h5555), 0, 1);
    @(posedge clk); #1 pix_ready = 1'b0;
    @(negedge clk);
    chk("b_empty", 32'(pix_valid), 32'd0);
    chk("b_leer_resume", 32'(leer), 32'd1);

    // Mid-line reset
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    pulse_start;
    strobe_byte(8'h11);
    strobe_byte(8'h22);
    strobe_byte(8'h33);
    @(negedge clk);
    chk("c_valid_pre", 32'(pix_valid), 32'd1);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("c_rst_valid", 32'(pix_valid), 32'd0);
    chk("c_rst_busy", 32'(busy), 32'd0);
    chk("c_rst_leer", 32'(leer), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    strobe_byte(8'h99);
    @(negedge clk);
    chk("c_idle_strobe_busy", 32'(busy), 32'd0);
    chk("c_idle_strobe_valid", 32'(pix_valid), 32'd0);
    pix_ready = 1'b1;
    pulse_start;
    send_pixel(16'hABCD);
    @(negedge clk);
    chk_head("c_first", exp_pix(16'hABCD), 0, 0);
    send_pixel(16'hFFFF);
    @(negedge clk);
`ifdef CAM_GRAY_EN
    chk_head("c_white", 16'h00FA, 1, 0);
`else
    chk_head("c_white", 16'hFFFF, 1, 0);
`endif
    send_pixel(16'hF800);
    @(negedge clk);
`ifdef CAM_GRAY_EN
    chk_head("c_red", 16'h003E, 2, 0);
`else
    chk_head("c_red", 16'hF800, 2, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
